// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: shared size codes, FSM states and captured-request type
package mem_access_ctrl_pkg;
  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} mem_state_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sign;
    logic        we;
  } mem_req_type;
endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: pipeline-side and data-memory-side signals of the MEM-stage port
interface mem_access_ctrl_if import mem_access_ctrl_pkg::*; ();
  logic        req_valid, mem_read, mem_write, mem_sign, flush;
  logic [1:0]  mem_size;
  logic [31:0] addr, wdata;
  logic        stall, done, fault;
  logic [31:0] rdata;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  modport master (
    input  req_valid, mem_read, mem_write, mem_size, mem_sign, addr, wdata, flush,
    input  dmem_gnt, dmem_rvalid, dmem_rdata,
    output stall, done, rdata, fault,
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
  );
  modport slave (
    output req_valid, mem_read, mem_write, mem_size, mem_sign, addr, wdata, flush,
    output dmem_gnt, dmem_rvalid, dmem_rdata,
    input  stall, done, rdata, fault,
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
  );
endinterface

// File: rtl/mem_access_ctrl_lsu_align.sv
// lsu_align: byte enables, store lane replication and load extraction/extension
module lsu_align import mem_access_ctrl_pkg::*; (
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rword_i[{off_i, 3'b000} +: 8];
  assign h = rword_i[{off_i[1], 4'b0000} +: 16];
  // size selects lane pattern for stores and the extension width for loads
  always_comb begin
    be_o    = size_i == MEM_BYTE ? 4'b0001 << off_i : size_i == MEM_HALF ? 4'b0011 << off_i : 4'b1111;
    wdata_o = size_i == MEM_BYTE ? {4{wdata_i[7:0]}} : size_i == MEM_HALF ? {2{wdata_i[15:0]}} : wdata_i;
    rdata_o = size_i == MEM_BYTE ? {{24{sign_i & b[7]}}, b} :
              size_i == MEM_HALF ? {{16{sign_i & h[15]}}, h} : rword_i;
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory sequencer with stall, fault and timeout
module mem_access_ctrl import mem_access_ctrl_pkg::*; #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input logic clk,
  input logic reset,
  mem_access_ctrl_if.master bus
);
  mem_state_t  state_q, state_d;
  mem_req_type req_q, req_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d, supp_q, supp_d, dreq_q, dreq_d;
  logic        cap, illegal, tmo, supp;
  logic [3:0]  be;
  logic [31:0] wrep, rext;
  assign cap     = bus.req_valid & (bus.mem_read | bus.mem_write) & ~bus.flush;
  assign illegal = (bus.mem_read & bus.mem_write) | (bus.mem_size == 2'b11) |
                   (bus.mem_size == MEM_HALF & bus.addr[0]) |
                   (bus.mem_size == MEM_WORD & bus.addr[1:0] != 2'b00);
  assign tmo     = cnt_q == TIMEOUT - 8'd1;
  assign supp    = supp_q | bus.flush;
  lsu_align u_align (
    .off_i(req_q.addr[1:0]), .size_i(req_q.size), .sign_i(req_q.sign),
    .wdata_i(req_q.wdata), .rword_i(bus.dmem_rdata),
    .be_o(be), .wdata_o(wrep), .rdata_o(rext)
  );
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  // next state: a flushed access that was already granted still drains its response
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = cap ? (illegal ? DONE : REQ) : IDLE;
      REQ:     state_d = bus.flush ? ((bus.dmem_gnt & ~req_q.we) ? WAIT : IDLE) :
                         bus.dmem_gnt ? (req_q.we ? DONE : WAIT) : tmo ? DONE : REQ;
      WAIT:    state_d = (bus.dmem_rvalid | tmo) ? (supp ? IDLE : DONE) : WAIT;
      default: state_d = IDLE;
    endcase
  end
  // datapath next values: fault is only consumed on the way into DONE
  always_comb begin
    req_d   = (state_q == IDLE && cap) ? '{addr: bus.addr, wdata: bus.wdata, size: bus.mem_size,
                                          sign: bus.mem_sign, we: bus.mem_write} : req_q;
    fault_d = state_q == IDLE ? illegal : state_q == REQ ? ~bus.dmem_gnt : ~bus.dmem_rvalid;
    supp_d  = state_q == IDLE ? 1'b0 : supp;
    rdata_d = (state_q == WAIT && bus.dmem_rvalid && !supp) ? rext : '0;
    cnt_d   = (state_d == state_q && (state_q == REQ || state_q == WAIT)) ? cnt_q + 8'd1 : 8'd0;
    dreq_d  = state_d == REQ;
  end
  // datapath registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      req_q   <= '0;
      fault_q <= 1'b0;
      supp_q  <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
      dreq_q  <= 1'b0;
    end else begin
      req_q   <= req_d;
      fault_q <= fault_d;
      supp_q  <= supp_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      dreq_q  <= dreq_d;
    end
  // outputs: memory fields are gated so they read 0 whenever no request is up
  always_comb begin
    bus.stall      = (state_q == IDLE & cap) | state_q == REQ | state_q == WAIT;
    bus.done       = state_q == DONE;
    bus.fault      = state_q == DONE & fault_q;
    bus.rdata      = state_q == DONE ? rdata_q : '0;
    bus.dmem_req   = dreq_q;
    bus.dmem_we    = dreq_q & req_q.we;
    bus.dmem_addr  = dreq_q ? {req_q.addr[31:2], 2'b00} : '0;
    bus.dmem_be    = dreq_q ? be : '0;
    bus.dmem_wdata = dreq_q ? wrep : '0;
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed-vector bench for the MEM-stage data-memory sequencer
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  mem_access_ctrl_if bus();
  mem_access_ctrl #(.TIMEOUT(8'd4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clr;
    bus.req_valid = 0; bus.mem_read = 0; bus.mem_write = 0; bus.mem_size = 0;
    bus.mem_sign = 0; bus.addr = 0; bus.wdata = 0; bus.flush = 0;
    bus.dmem_gnt = 0; bus.dmem_rvalid = 0; bus.dmem_rdata = 0;
  endtask
  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.req_valid = 1; bus.mem_read = rd; bus.mem_write = wr; bus.mem_size = sz;
    bus.mem_sign = sg; bus.addr = a; bus.wdata = wd;
  endtask
  task automatic idle_outs(input string tag);
    chk({tag, " stall"}, bus.stall, 0);
    chk({tag, " done"}, bus.done, 0);
    chk({tag, " fault"}, bus.fault, 0);
    chk({tag, " rdata"}, bus.rdata, 0);
    chk({tag, " dmem_req"}, bus.dmem_req, 0);
    chk({tag, " dmem_we"}, bus.dmem_we, 0);
    chk({tag, " dmem_addr"}, bus.dmem_addr, 0);
    chk({tag, " dmem_be"}, bus.dmem_be, 0);
    chk({tag, " dmem_wdata"}, bus.dmem_wdata, 0);
  endtask
  task automatic run_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                          input logic sg, input logic [31:0] word, input logic [31:0] exp);
    issue(1, 0, sz, sg, a, 0);
    #1 chk({tag, " stall c0"}, bus.stall, 1);
    tick;
    chk({tag, " req c1"}, bus.dmem_req, 1);
    chk({tag, " addr c1"}, bus.dmem_addr, {a[31:2], 2'b00});
    chk({tag, " we c1"}, bus.dmem_we, 0);
    chk({tag, " stall c1"}, bus.stall, 1);
    bus.dmem_gnt = 1;
    tick;
    bus.dmem_gnt = 0;
    chk({tag, " req c2"}, bus.dmem_req, 0);
    chk({tag, " stall c2"}, bus.stall, 1);
    tick;
    bus.dmem_rvalid = 1; bus.dmem_rdata = word;
    chk({tag, " stall c3"}, bus.stall, 1);
    chk({tag, " done c3"}, bus.done, 0);
    tick;
    clr;
    chk({tag, " done c4"}, bus.done, 1);
    chk({tag, " rdata c4"}, bus.rdata, exp);
    chk({tag, " fault c4"}, bus.fault, 0);
    chk({tag, " stall c4"}, bus.stall, 0);
    tick;
    chk({tag, " done c5"}, bus.done, 0);
  endtask
  task automatic run_store(input string tag, input logic [31:0] a, input logic [1:0] sz,
                           input logic [31:0] wd, input logic [3:0] ebe, input logic [31:0] ewd);
    issue(0, 1, sz, 0, a, wd);
    #1 chk({tag, " stall c0"}, bus.stall, 1);
    tick;
    chk({tag, " req c1"}, bus.dmem_req, 1);
    chk({tag, " we c1"}, bus.dmem_we, 1);
    chk({tag, " addr c1"}, bus.dmem_addr, {a[31:2], 2'b00});
    chk({tag, " be c1"}, bus.dmem_be, ebe);
    chk({tag, " wdata c1"}, bus.dmem_wdata, ewd);
    chk({tag, " stall c1"}, bus.stall, 1);
    bus.dmem_gnt = 1;
    tick;
    clr;
    chk({tag, " done c2"}, bus.done, 1);
    chk({tag, " fault c2"}, bus.fault, 0);
    chk({tag, " rdata c2"}, bus.rdata, 0);
    chk({tag, " stall c2"}, bus.stall, 0);
    chk({tag, " req c2"}, bus.dmem_req, 0);
    tick;
    chk({tag, " done c3"}, bus.done, 0);
  endtask
  task automatic run_bad(input string tag, input logic rd, input logic wr,
                         input logic [1:0] sz, input logic [31:0] a);
    issue(rd, wr, sz, 0, a, 32'h5555_5555);
    #1 chk({tag, " stall c0"}, bus.stall, 1);
    tick;
    chk({tag, " req c1"}, bus.dmem_req, 0);
    chk({tag, " done c1"}, bus.done, 1);
    chk({tag, " fault c1"}, bus.fault, 1);
    chk({tag, " rdata c1"}, bus.rdata, 0);
    clr;
    tick;
    chk({tag, " done c2"}, bus.done, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    clr;
    tick;
    idle_outs("reset");
    tick;
    reset = 0;
    tick;
    idle_outs("idle");
    run_load("lw", 32'h100, MEM_WORD, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    run_load("lb", 32'h103, MEM_BYTE, 1, 32'h8012_3456, 32'hFFFF_FF80);
    run_load("lbu", 32'h103, MEM_BYTE, 0, 32'h8012_3456, 32'h0000_0080);
    run_load("lbu1", 32'h101, MEM_BYTE, 0, 32'h0000_AB00, 32'h0000_00AB);
    run_load("lh", 32'h102, MEM_HALF, 1, 32'h8001_7FFF, 32'hFFFF_8001);
    run_load("lhu", 32'h100, MEM_HALF, 0, 32'h8001_7FFF, 32'h0000_7FFF);
    run_store("sh", 32'h102, MEM_HALF, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
    run_store("sb", 32'h101, MEM_BYTE, 32'h0000_0077, 4'b0010, 32'h7777_7777);
    run_store("sw", 32'h104, MEM_WORD, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
    run_bad("lw_mis", 1, 0, MEM_WORD, 32'h101);
    run_bad("sh_mis", 0, 1, MEM_HALF, 32'h101);
    run_bad("rw_both", 1, 1, MEM_WORD, 32'h100);
    run_bad("size11", 1, 0, 2'b11, 32'h100);
    // timeout: gnt withheld for four REQ cycles
    issue(1, 0, MEM_WORD, 0, 32'h200, 0);
    for (int i = 1; i <= 4; i++) begin
      tick;
      chk($sformatf("tmo req c%0d", i), bus.dmem_req, 1);
      chk($sformatf("tmo done c%0d", i), bus.done, 0);
    end
    tick;
    clr;
    chk("tmo done", bus.done, 1);
    chk("tmo fault", bus.fault, 1);
    chk("tmo req drop", bus.dmem_req, 0);
    chk("tmo rdata", bus.rdata, 0);
    tick;
    bus.dmem_rvalid = 1; bus.dmem_rdata = 32'h1234_5678;
    #1 chk("late rvalid stall", bus.stall, 0);
    tick;
    bus.dmem_rvalid = 0;
    chk("late rvalid done", bus.done, 0);
    chk("late rvalid req", bus.dmem_req, 0);
    // flush in REQ without gnt
    issue(1, 0, MEM_WORD, 0, 32'h100, 0);
    tick;
    bus.flush = 1;
    chk("flreq req", bus.dmem_req, 1);
    tick;
    clr;
    chk("flreq idle req", bus.dmem_req, 0);
    chk("flreq stall", bus.stall, 0);
    chk("flreq done", bus.done, 0);
    tick;
    chk("flreq done2", bus.done, 0);
    // flush in WAIT: rvalid consumed silently
    issue(1, 0, MEM_WORD, 0, 32'h100, 0);
    tick;
    bus.dmem_gnt = 1;
    tick;
    clr;
    bus.flush = 1;
    tick;
    bus.flush = 0; bus.dmem_rvalid = 1; bus.dmem_rdata = 32'hDEAD_BEEF;
    chk("flwait stall", bus.stall, 1);
    tick;
    bus.dmem_rvalid = 0;
    chk("flwait done", bus.done, 0);
    chk("flwait stall2", bus.stall, 0);
    chk("flwait rdata", bus.rdata, 0);
    tick;
    chk("flwait done2", bus.done, 0);
    // back-to-back: request held during DONE is captured only in the next IDLE
    issue(0, 1, MEM_WORD, 0, 32'h300, 32'h1111_1111);
    tick;
    bus.dmem_gnt = 1;
    tick;
    bus.dmem_gnt = 0;
    issue(1, 0, MEM_WORD, 0, 32'h304, 0);
    chk("b2b done", bus.done, 1);
    #1 chk("b2b stall in done", bus.stall, 0);
    tick;
    chk("b2b capture stall", bus.stall, 1);
    chk("b2b capture req", bus.dmem_req, 0);
    tick;
    chk("b2b req", bus.dmem_req, 1);
    chk("b2b addr", bus.dmem_addr, 32'h304);
    chk("b2b we", bus.dmem_we, 0);
    bus.flush = 1;
    tick;
    clr;
    chk("b2b flushed", bus.done, 0);
    // reset during REQ drops dmem_req immediately
    issue(0, 1, MEM_WORD, 0, 32'h400, 32'hA5A5_A5A5);
    tick;
    chk("rstreq req", bus.dmem_req, 1);
    clr;
    #2 reset = 1;
    #1 idle_outs("rstreq");
    tick;
    reset = 0;
    tick;
    chk("rstreq done after", bus.done, 0);
    // reset during WAIT clears every output immediately
    issue(1, 0, MEM_WORD, 0, 32'h100, 0);
    tick;
    bus.dmem_gnt = 1;
    tick;
    clr;
    chk("rstwait stall", bus.stall, 1);
    #2 reset = 1;
    #1 idle_outs("rstwait");
    tick;
    reset = 0;
    bus.dmem_rvalid = 1; bus.dmem_rdata = 32'hDEAD_BEEF;
    tick;
    bus.dmem_rvalid = 0;
    chk("rstwait done after", bus.done, 0);
    chk("rstwait stall after", bus.stall, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer for the MEM-stage data-memory port of the RV32I pipeline. It takes the decoded memory controls (read/write, size, sign) with the effective address and store data. It then runs a request/grant/response handshake to data memory and stalls the pipeline for the whole access. Loads return aligned and sign- or zero-extended data; misaligned accesses, illegal encodings and memory timeouts end with a fault pulse instead of an access.

## Interface
Clocking: one clock; reset is asynchronous and active-high.

Parameters:
- TIMEOUT, 255: cycles allowed in REQ or WAIT before fault; width 8 bits; 0 is illegal.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  MEM stage holds a load or store
- mem_read  in  1  load
- mem_write  in  1  store
- mem_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- mem_sign  in  1  1 = sign-extend load
- addr  in  32  effective byte address
- wdata  in  32  store data, LSB-justified
- flush  in  1  kill the current access
- stall  out  1  hold the pipeline
- done  out  1  one-cycle completion pulse
- rdata  out  32  extended load data, valid with done
- fault  out  1  with done: misaligned, illegal or timeout
- dmem_req  out  1  memory request
- dmem_we  out  1  write enable
- dmem_addr  out  32  word address ({addr[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load data word

## Operation
- States:
  - IDLE: waiting for an access.
  - REQ: dmem_req high until dmem_gnt.
  - WAIT: load in flight, waiting for dmem_rvalid.
  - DONE: completion cycle.
- Access capture: in IDLE with req_valid && (mem_read||mem_write) && !flush, latch addr, size, sign, we and wdata.
- Legality check at capture:
  - Illegal when any of: both read and write set, size 11, half with addr[0]=1, word with addr[1:0]≠0.
  - Illegal → DONE with fault pending; no memory request is issued.
  - Legal → REQ.
- REQ:
  - dmem_gnt with a store → DONE.
  - dmem_gnt with a load → WAIT.
  - flush without gnt → IDLE, no done.
  - flush with gnt → access is committed; store → IDLE silently; load → WAIT with the result suppressed.
- WAIT: dmem_rvalid → capture extended data → DONE, or → IDLE when the access was flushed. flush in WAIT marks the access suppressed; the controller still waits for rvalid.
- Timeout:
  - Counter clears on entering REQ or WAIT and increments each cycle there.
  - At TIMEOUT, go to DONE with fault, drop dmem_req and discard any later rvalid.
- dmem_rvalid outside WAIT is ignored.
- DONE: done=1 and fault as latched, then → IDLE.
- Byte enables: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
- Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word as is.
- Load data:
  - byte = dmem_rdata[8*addr[1:0]+:8], extended to 32 bits per mem_sign.
  - half = dmem_rdata[16*addr[1]+:16], extended to 32 bits per mem_sign.
  - word passes through unchanged.
- rdata is 0 on faults and stores.

## Timing
- Reset values:
  - All outputs 0; state IDLE; counter 0.
  - Reset mid-access drops dmem_req asynchronously; no done follows.
- stall (combinational): 1 when IDLE sees a capturable access; 1 in REQ and WAIT; 0 in DONE and in idle IDLE.
- dmem_* outputs are registered from latched fields and valid only while dmem_req=1. dmem_we is held through REQ.
- Store latency with gnt on the first REQ cycle: capture in C0, REQ in C1, done in C2; stall is high C0–C1.
- Load latency: done 1 cycle after the rvalid cycle.
- Illegal access: stall in C0, done+fault in C1.
- Back-to-back: in DONE a new req_valid is not captured; capture happens in the following IDLE cycle. The pipeline advances during the DONE cycle.

## Structure
- Package common gets:
  - MEM_BYTE/MEM_HALF/MEM_WORD size constants;
  - mem_state_t enum {IDLE, REQ, WAIT, DONE};
  - mem_req_type struct (addr, wdata, size, sign, we).
- Sub-module: lsu_align, a combinational block for byte-enable generation, store replication and load extraction/extension. It is reused by the verification model.

## Test plan
- LW at addr 0x100: gnt in C1, rvalid in C3 with 0xDEADBEEF → done in C4, rdata=0xDEADBEEF, stall high C0–C3.
- LB at 0x103 with mem_sign=1, rdata 0x80xxxxxx → rdata=0xFFFFFF80; same access as LBU → rdata=0x00000080.
- SH at 0x102 with wdata 0x1234ABCD → dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_addr=0x100, done with no fault.
- LW at 0x101 → no dmem_req; done+fault next cycle.
- Misaligned half (SH at 0x101) → fault.
- mem_read=mem_write=1 → fault.
- gnt withheld with TIMEOUT=4 → fault after 4 REQ cycles and dmem_req drops; a later rvalid leaves the state at IDLE.
- flush in REQ without gnt → IDLE with no done.
- flush in WAIT → rvalid consumed, no done.
- reset asserted in WAIT → all outputs 0 immediately.
